// File: rtl/ahb_ram64_excl_slave_if.sv
// AHB-Lite bus bundle between the 64-bit file-reader master and the RAM slave.
// Clock and reset stay outside the bundle as plain ports.
interface ahb_ram64_excl_slave_if;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [63:0] HWDATA;
  logic        EXREQ;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic        EXRESP;

  modport slave (
    input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, EXREQ,
    output HREADYOUT, HRESP, HRDATA, EXRESP
  );

  modport master (
    output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA, EXREQ,
    input  HREADYOUT, HRESP, HRDATA, EXRESP
  );
endinterface

// File: rtl/ahb_ram64_excl_slave.sv
// 64-bit AHB-Lite RAM slave with programmable wait states, two-cycle error
// response and a single-entry exclusive-access monitor (doubleword granularity).
module ahb_ram64_excl_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int WAITSTATES = 1
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_ram64_excl_slave_if.slave bus
);

  if (WAITSTATES < 0 || WAITSTATES > 15) begin : g_bad_waitstates
    $error("WAITSTATES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  localparam int         WORDS     = 2 ** (ADDR_WIDTH - 3);
  localparam logic [3:0] WAIT_INIT = 4'(WAITSTATES);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  // Data-phase copy of the accepted address phase
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        exreq_q;

  logic        mon_valid;
  logic [28:0] mon_tag;

  logic [63:0] mem [WORDS];

  logic                  ready_now;
  logic                  accept;
  logic                  addr_err;
  logic                  completing;
  logic                  tag_hit;
  logic                  ex_fail;
  logic                  do_write;
  logic [7:0]            byte_en;
  logic [ADDR_WIDTH-4:0] word_idx;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // The slave can take a new address phase only when its current data phase
  // (if any) is ending; ERR2 is the ending cycle of an error response.
  assign ready_now  = (state == IDLE) || (state == ERR2) ||
                      (state == DATA && cnt == 4'd0);
  assign accept     = ready_now && bus.HSEL && bus.HREADY && bus.HTRANS[1];
  assign completing = (state == DATA) && (cnt == 4'd0);
  assign word_idx   = addr_q[ADDR_WIDTH-1:3];
  assign tag_hit    = mon_valid && (mon_tag == addr_q[31:3]);
  assign ex_fail    = completing && write_q && exreq_q && !tag_hit;
  assign do_write   = completing && write_q && !ex_fail;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    addr_err = 1'b0;
    if (bus.HSIZE > 3'd3) addr_err = 1'b1;
    case (bus.HSIZE)
      3'd1:    if (bus.HADDR[0])      addr_err = 1'b1;
      3'd2:    if (|bus.HADDR[1:0])   addr_err = 1'b1;
      3'd3:    if (|bus.HADDR[2:0])   addr_err = 1'b1;
      default: ;
    endcase
    if (|bus.HADDR[31:ADDR_WIDTH]) addr_err = 1'b1;
  end

  always_comb begin
    byte_en = 8'h00;
    case (size_q)
      2'd0:    byte_en = 8'h01 << addr_q[2:0];
      2'd1:    byte_en = 8'h03 << addr_q[2:0];
      2'd2:    byte_en = 8'h0F << addr_q[2:0];
      default: byte_en = 8'hFF;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.HREADYOUT = ready_now;
    bus.HRESP     = (state == ERR1) || (state == ERR2);
    bus.HRDATA    = 64'h0;
    bus.EXRESP    = ex_fail;

    case (state)
      DATA:    if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
      ERR1:    state_nxt = ERR2;
      default: ;
    endcase

    if (completing && !write_q) bus.HRDATA = mem[word_idx];

    if (ready_now) begin
      if (accept) begin
        state_nxt = addr_err ? ERR1 : DATA;
        cnt_nxt   = addr_err ? 4'd0 : WAIT_INIT;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'h0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
      exreq_q   <= 1'b0;
      mon_valid <= 1'b0;
      mon_tag   <= 29'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= bus.HADDR;
        size_q  <= bus.HSIZE[1:0];
        write_q <= bus.HWRITE;
        exreq_q <= bus.EXREQ;
      end
      // Monitor changes only when a good transfer completes; errors never reach DATA.
      if (completing) begin
        if (!write_q && exreq_q) begin
          mon_valid <= 1'b1;
          mon_tag   <= addr_q[31:3];
        end else if (write_q && (exreq_q || tag_hit)) begin
          mon_valid <= 1'b0;
        end
      end
    end
  end

  // NOTE: the RAM array has no reset; a reset only drops the FSM to IDLE, which blocks do_write.
  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_ram64_excl_slave.sv
// Scoreboard bench: the driver queues expected responses as address phases are
// accepted; a monitor pops and compares whenever a data phase completes.
module tb_ahb_ram64_excl_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_ram64_excl_slave_if bus0 ();
  ahb_ram64_excl_slave_if bus1 ();

  ahb_ram64_excl_slave #(.ADDR_WIDTH(12), .WAITSTATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .bus(bus0.slave));
  ahb_ram64_excl_slave #(.ADDR_WIDTH(12), .WAITSTATES(1)) dut1 (
    .HCLK(clk), .HRESET(rst), .bus(bus1.slave));

  // Shared master signals; sel chooses which slave sees the transfer
  int          sel   = 0;
  logic [1:0]  trans = 2'b00;
  logic [2:0]  size  = 3'd0;
  logic        write = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [63:0] wdata = 64'h0;
  logic        exreq = 1'b0;

  assign bus0.HSEL   = (sel == 0);
  assign bus0.HTRANS = (sel == 0) ? trans : 2'b00;
  assign bus0.HSIZE  = size;
  assign bus0.HWRITE = write;
  assign bus0.HADDR  = addr;
  assign bus0.HWDATA = wdata;
  assign bus0.EXREQ  = exreq;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HSEL   = (sel == 1);
  assign bus1.HTRANS = (sel == 1) ? trans : 2'b00;
  assign bus1.HSIZE  = size;
  assign bus1.HWRITE = write;
  assign bus1.HADDR  = addr;
  assign bus1.HWDATA = wdata;
  assign bus1.EXREQ  = exreq;
  assign bus1.HREADY = bus1.HREADYOUT;

  logic        ro  [2];
  logic        rr  [2];
  logic [63:0] rd  [2];
  logic        ex  [2];
  logic        acc [2];
  assign ro[0]  = bus0.HREADYOUT;
  assign rr[0]  = bus0.HRESP;
  assign rd[0]  = bus0.HRDATA;
  assign ex[0]  = bus0.EXRESP;
  assign acc[0] = bus0.HSEL & bus0.HTRANS[1];
  assign ro[1]  = bus1.HREADYOUT;
  assign rr[1]  = bus1.HRESP;
  assign rd[1]  = bus1.HRDATA;
  assign ex[1]  = bus1.EXRESP;
  assign acc[1] = bus1.HSEL & bus1.HTRANS[1];

  typedef struct {
    int          dut;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        exreq;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic        exp_ex;
    int          exp_waits;
    string       name;
  } txn_t;

  txn_t tx_q  [$];
  txn_t exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(input int dut, input bit w, input logic [2:0] sz,
                              input logic [31:0] a, input logic [63:0] wd, input bit x,
                              input logic [63:0] er, input bit ee, input bit ex_exp,
                              input string nm);
    txn_t t;
    t.dut = dut; t.write = w; t.size = sz; t.addr = a; t.wdata = wd; t.exreq = x;
    t.exp_rdata = er; t.exp_err = ee; t.exp_ex = ex_exp; t.name = nm;
    // dut0 is built with 0 wait states, dut1 with 1; errors always take one ERR1 cycle
    t.exp_waits = ee ? 1 : dut;
    tx_q.push_back(t);
  endfunction

  // Monitor / scoreboard
  int pend      [2] = '{0, 0};
  int waits     [2] = '{0, 0};
  bit wait_ok   [2] = '{1, 1};
  bit wait_resp [2] = '{0, 0};

  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int d = 0; d < 2; d++) pend[d] = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (pend[d] != 0) begin
            if (!ro[d]) begin
              if (waits[d] == 0) wait_resp[d] = rr[d];
              waits[d]++;
              if (rd[d] != 64'h0 || ex[d]) wait_ok[d] = 1'b0;
            end else begin
              if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_completion: dut%0d completed with no queued transfer", d);
              end else begin
                e = exp_q.pop_front();
                check({e.name, "_dut"},   64'(d),         64'(e.dut));
                check({e.name, "_waits"}, 64'(waits[d]),  64'(e.exp_waits));
                check({e.name, "_hresp"}, 64'(rr[d]),     64'(e.exp_err));
                check({e.name, "_rdata"}, rd[d],          e.exp_rdata);
                check({e.name, "_exresp"}, 64'(ex[d]),    64'(e.exp_ex));
                check({e.name, "_quiet_waits"}, 64'(wait_ok[d]), 64'd1);
                if (waits[d] > 0) check({e.name, "_wait_hresp"}, 64'(wait_resp[d]), 64'(e.exp_err));
              end
              pend[d] = 0;
            end
          end
          if (acc[d] && ro[d]) begin
            pend[d]    = 1;
            waits[d]   = 0;
            wait_ok[d] = 1'b1;
          end
        end
      end
    end
  end

  // Driver: pipelines address phases, supplies write data in the data phase
  task automatic run_txns();
    txn_t cur;
    bit   busy_addr = 0;
    logic rdy;
    int   guard = 0;
    int   g = 0;
    while ((tx_q.size() > 0 || busy_addr) && guard < 500) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
      @(posedge clk); #1;
      guard++;
      if (rdy) begin
        if (busy_addr) begin
          wdata = cur.wdata;
          exp_q.push_back(cur);
        end
        if (tx_q.size() > 0) begin
          cur   = tx_q.pop_front();
          sel   = cur.dut;
          trans = 2'b10;
          size  = cur.size;
          write = cur.write;
          addr  = cur.addr;
          exreq = cur.exreq;
          busy_addr = 1;
        end else begin
          trans = 2'b00;
          write = 1'b0;
          exreq = 1'b0;
          busy_addr = 0;
        end
      end
    end
    while ((exp_q.size() > 0 || pend[0] != 0 || pend[1] != 0) && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("drain_timeout", 64'(g >= 100), 64'd0);
    check("drain_left", 64'(exp_q.size() + tx_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm, input int d);
    check({nm, "_hreadyout"}, 64'(ro[d]), 64'd1);
    check({nm, "_hresp"},     64'(rr[d]), 64'd0);
    check({nm, "_exresp"},    64'(ex[d]), 64'd0);
    check({nm, "_hrdata"},    rd[d],      64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    check_reset_outputs("reset0", 0);
    check_reset_outputs("reset1", 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // One wait state: full write, readback, byte merge
    add(1, 1, 3'd3, 32'h10, 64'h1122334455667788, 0, 64'h0, 0, 0, "w10");
    add(1, 0, 3'd3, 32'h10, 64'h0, 0, 64'h1122334455667788, 0, 0, "r10");
    add(1, 1, 3'd0, 32'h13, 64'hFFFFFFFF_AAFFFFFF, 0, 64'h0, 0, 0, "wb13");
    add(1, 0, 3'd3, 32'h10, 64'h0, 0, 64'h11223344AA667788, 0, 0, "r10_merged");
    run_txns();

    // Zero wait states: back-to-back write/read and the error cases
    add(0, 1, 3'd3, 32'h00, 64'h0123456789ABCDEF, 0, 64'h0, 0, 0, "w00");
    add(0, 1, 3'd3, 32'h20, 64'hDEADBEEF_CAFEF00D, 0, 64'h0, 0, 0, "w20");
    add(0, 0, 3'd3, 32'h20, 64'h0, 0, 64'hDEADBEEF_CAFEF00D, 0, 0, "r20");
    add(0, 1, 3'd2, 32'h06, 64'hFFFFFFFF_FFFFFFFF, 0, 64'h0, 1, 0, "w06_misaligned");
    add(0, 0, 3'd3, 32'h00, 64'h0, 0, 64'h0123456789ABCDEF, 0, 0, "r00_after_err");
    add(0, 0, 3'd4, 32'h00, 64'h0, 0, 64'h0, 1, 0, "r00_size4");
    add(0, 0, 3'd3, 32'h1000, 64'h0, 0, 64'h0, 1, 0, "r1000_range");
    add(0, 0, 3'd3, 32'h00, 64'h0, 0, 64'h0123456789ABCDEF, 0, 0, "r00_final");
    run_txns();

    // Exclusive monitor: pass, repeat fails (different data proves suppression),
    // then a normal write into the tagged doubleword breaks the reservation
    add(1, 1, 3'd3, 32'h40, 64'h0, 0, 64'h0, 0, 0, "w40_init");
    add(1, 0, 3'd3, 32'h40, 64'h0, 1, 64'h0, 0, 0, "xr40");
    add(1, 1, 3'd3, 32'h40, 64'h5, 1, 64'h0, 0, 0, "xw40_pass");
    add(1, 0, 3'd3, 32'h40, 64'h0, 0, 64'h5, 0, 0, "r40_5");
    add(1, 1, 3'd3, 32'h40, 64'h99, 1, 64'h0, 0, 1, "xw40_fail");
    add(1, 0, 3'd3, 32'h40, 64'h0, 0, 64'h5, 0, 0, "r40_still5");
    add(1, 0, 3'd3, 32'h40, 64'h0, 1, 64'h5, 0, 0, "xr40_again");
    add(1, 1, 3'd2, 32'h44, 64'h12345678_00000000, 0, 64'h0, 0, 0, "w44");
    add(1, 1, 3'd3, 32'h40, 64'h77, 1, 64'h0, 0, 1, "xw40_broken");
    add(1, 0, 3'd3, 32'h40, 64'h0, 0, 64'h12345678_00000005, 0, 0, "r40_final");
    run_txns();

    // Reset during a write wait state
    add(1, 1, 3'd3, 32'h80, 64'hA5A50000_11112222, 0, 64'h0, 0, 0, "w80");
    add(1, 0, 3'd3, 32'h80, 64'h0, 1, 64'hA5A50000_11112222, 0, 0, "xr80");
    run_txns();
    @(posedge clk); #1;
    sel = 1; trans = 2'b10; write = 1'b1; size = 3'd3; addr = 32'h80; exreq = 1'b0;
    @(posedge clk); #1;
    trans = 2'b00; write = 1'b0;
    wdata = 64'hBAD0BAD0_BAD0BAD0;
    check("rst_wait_hreadyout", 64'(ro[1]), 64'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid", 1);
    @(posedge clk); #1;
    rst = 1'b0;
    add(1, 0, 3'd3, 32'h80, 64'h0, 0, 64'hA5A50000_11112222, 0, 0, "r80_after_rst");
    add(1, 1, 3'd3, 32'h80, 64'h33, 1, 64'h0, 0, 1, "xw80_monitor_cleared");
    add(1, 0, 3'd3, 32'h80, 64'h0, 0, 64'hA5A50000_11112222, 0, 0, "r80_final");
    run_txns();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
